// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - byte-serial big-endian instruction fetch with valid/ready output
// Optional misaligned-redirect rejection is built when FETCH_ALIGN_CHECK_EN is defined.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              misalign_err
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        iss_q, iss_d;
  logic [2:0]        cap_q, cap_d;
  logic              pend_q, pend_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              instr_valid_q, instr_valid_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] redir_pc;
  logic              redir_take;

`ifdef FETCH_ALIGN_CHECK_EN
  logic              misalign_q, misalign_d;
  logic              redir_bad;
`endif

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    iss_d         = iss_q;
    cap_d         = cap_q;
    asm_d         = asm_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    mem_rd_en_d   = 1'b0;
    mem_addr_d    = mem_addr_q;
    redir_pc      = redirect_pc & ~ADDR_W'(3);
`ifdef FETCH_ALIGN_CHECK_EN
    redir_bad     = redirect_valid & (redirect_pc[1:0] != 2'b00);
    redir_take    = redirect_valid & ~redir_bad;
    misalign_d    = misalign_q | redir_bad;
`else
    redir_take    = redirect_valid;
`endif
    // The byte issued this cycle returns next cycle; a redirect orphans it.
    pend_d        = mem_rd_en_q & ~redir_take;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redir_take) pc_d = redir_pc;
      end
      FETCH: begin
        if (!redir_take) begin
          if (pend_q) begin
            asm_d = {asm_q[15:0], mem_rdata};
            cap_d = cap_q + 3'd1;
            if (cap_q == 3'd3) begin
              state_d       = VALID;
              instr_d       = {asm_q, mem_rdata};
              instr_pc_d    = pc_q;
              instr_valid_d = 1'b1;
            end
          end
          if (iss_q < 3'd4) begin
            mem_rd_en_d = 1'b1;
            mem_addr_d  = pc_q + ADDR_W'(iss_q);
            iss_d       = iss_q + 3'd1;
          end
        end
      end
      VALID: begin
        // Issue byte 0 of the next word on the accept edge to keep a 6-cycle cadence.
        if (!redir_take && instr_ready) begin
          state_d       = FETCH;
          pc_d          = pc_q + ADDR_W'(4);
          cap_d         = 3'd0;
          iss_d         = 3'd1;
          mem_rd_en_d   = 1'b1;
          mem_addr_d    = pc_q + ADDR_W'(4);
          instr_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redir_take && state_q != IDLE) begin
      state_d       = FETCH;
      pc_d          = redir_pc;
      cap_d         = 3'd0;
      iss_d         = 3'd1;
      mem_rd_en_d   = 1'b1;
      mem_addr_d    = redir_pc;
      instr_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      iss_q         <= 3'd0;
      cap_q         <= 3'd0;
      pend_q        <= 1'b0;
      asm_q         <= 24'd0;
      instr_q       <= 32'd0;
      instr_pc_q    <= RESET_PC;
      instr_valid_q <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      iss_q         <= iss_d;
      cap_q         <= cap_d;
      pend_q        <= pend_d;
      asm_q         <= asm_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_addr_q    <= mem_addr_d;
`ifdef FETCH_ALIGN_CHECK_EN
      misalign_q    <= misalign_d;
`endif
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_addr    = mem_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign_err = misalign_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Byte-serial instruction fetch unit for the MIPS core. It reads the 256-byte, byte-wide instruction memory one byte per cycle and assembles big-endian 32-bit instructions. It presents each instruction to the decode stage over a valid/ready handshake and supports PC redirect from branch/jump resolution. It sits between the instruction memory array and `main`'s decode logic.

## Interface
- `ADDR_W`, 8: byte-address width; memory depth is 2^ADDR_W bytes.
- `RESET_PC`, 0: byte address of the first fetch after reset; word-aligned.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_rd_en`  out  1  byte read strobe to instruction memory.
- `mem_addr`  out  ADDR_W  byte address of the read.
- `mem_rdata`  in  8  read data, valid exactly one cycle after the `mem_rd_en` cycle.
- `redirect_valid`  in  1  one-cycle request to restart fetch at `redirect_pc`.
- `redirect_pc`  in  ADDR_W  new fetch address.
- `instr`  out  32  assembled instruction; byte at `pc` maps to `[31:24]`.
- `instr_pc`  out  ADDR_W  byte address of `instr`.
- `instr_valid`  out  1  `instr` and `instr_pc` are valid.
- `instr_ready`  in  1  decode accepts `instr`.
- `misalign_err`  out  1  sticky flag for a misaligned redirect.

## Operation
- **States:** IDLE, FETCH, VALID. Reset forces IDLE.
- **Reset values:**
  - `pc` = RESET_PC; issue count and capture count = 0.
  - `instr` = 0, `instr_pc` = RESET_PC.
  - `instr_valid` = 0, `mem_rd_en` = 0, `mem_addr` = RESET_PC, `misalign_err` = 0.
- **IDLE:** moves to FETCH unconditionally on the next edge.
- **FETCH, issue side:** while issue count < 4, `mem_rd_en` = 1 and `mem_addr` = `pc` + issue count, modulo 2^ADDR_W. Issue count increments each cycle.
- **FETCH, capture side:**
  - Each returning byte is shifted into the assembly register, MSB first.
  - A capture happens only when the byte was issued in the current fetch sequence. Track this with a per-issue pending flag that redirect clears.
  - After the 4th capture, go to VALID.
- **VALID:**
  - `instr_valid` = 1; `instr` and `instr_pc` hold stable; `mem_rd_en` = 0.
  - On `instr_valid & instr_ready`: `pc` ← `pc` + 4 (wraps), counts clear, go to FETCH.
- **Redirect** (`redirect_valid` = 1, any state except IDLE):
  - `pc` ← `redirect_pc` with bits [1:0] forced to 0. Counts and pending flags clear.
  - Next state is FETCH and `instr_valid` drops on the next edge.
  - A byte in flight from the redirect cycle is discarded.
- **Redirect together with handshake:** redirect wins for `pc`. The instruction is still counted as consumed by decode; it is not re-presented.
- **Redirect in IDLE:** latched into `pc`; the FETCH entry proceeds normally.
- **Wrap-around:** a fetch at `pc` = 2^ADDR_W − 4 reads the top 4 bytes; the next `pc` is 0.

## Timing
- Issue cycles are F0..F3, with byte k issued in Fk.
- Byte k is captured at the end of cycle Fk+1.
- `instr_valid` rises in cycle F5: 5 cycles after the first issue, 6 after leaving IDLE.
- After a handshake in cycle T, the next F0 is T+1. Throughput is one instruction per 6 cycles with `instr_ready` held high.
- After a redirect in cycle T, F0 is T+1 at the new `pc`, and `instr_valid` is 0 from T+1.
- Asserting reset mid-operation clears all outputs asynchronously. Fetch resumes from RESET_PC: IDLE on the first edge after release, F0 on the second.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]` ≠ 0 is ignored: no state change and no discard.
  - `misalign_err` is set and stays set until reset.
- `FETCH_ALIGN_CHECK_EN` undefined:
  - The low two bits are silently forced to 0 and the redirect is taken.
  - `misalign_err` is tied to 0.

## Test plan
- **Basic fetch:** memory[0..3] = 20,0a,00,0a; RESET_PC = 0; `instr_ready` high. Required: `mem_addr` 0,1,2,3 on consecutive cycles; then `instr` = 0x200A000A, `instr_pc` = 0x00, `instr_valid` for 1 cycle at F5; next F0 issues address 0x04.
- **Backpressure:** `instr_ready` low for 3 cycles in VALID. Required: `instr` and `instr_pc` stable, `mem_rd_en` = 0 throughout, `pc` advances only on the accept cycle.
- **Redirect mid-fetch:** `redirect_valid` with `redirect_pc` = 0x40, asserted at F2. Required: the stale byte is dropped; the next cycle issues 0x40..0x43; `instr_pc` = 0x40 with the bytes from 0x40..0x43.
- **Wrap:** start at 0xFC, memory[0xFC..0xFF] = 8c,09,00,04. Required: `instr` = 0x8C090004; the following fetch issues address 0x00.
- **Reset mid-fetch:** drop reset at F1. Required: all outputs return to reset values immediately; after release the fetch restarts at RESET_PC with the timing above.
- **Misaligned redirect:** `redirect_pc` = 0x42. With the macro: `misalign_err` = 1 and the current fetch continues unaffected. Without the macro: fetch restarts at 0x40 and `misalign_err` stays 0.
